// File: rtl/config_splitter_reg.sv
// Registered config address splitter: decodes one config write against ascending
// address windows, forwards it through a one-deep back-pressured output stage, and
// drops/reports writes that fall outside every window.
module config_splitter_reg #(
    parameter int unsigned     NUM_CONFIGS       = 4,
    parameter int unsigned     ADDR_WIDTH        = 32,
    parameter int unsigned     DATA_WIDTH        = 64,
    parameter longint unsigned ADDR_SPACE_BOUNDS [NUM_CONFIGS+1] =
        '{64'd0, 64'd16, 64'd32, 64'd48, 64'd64},
    parameter int unsigned     SUBTRACT_BASE     = 1,
    parameter int unsigned     ERR_CNT_WIDTH     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [ADDR_WIDTH-1:0]                   in_addr,
    input  logic [DATA_WIDTH-1:0]                   in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [NUM_CONFIGS-1:0][ADDR_WIDTH-1:0]  out_addr,
    output logic [NUM_CONFIGS-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [NUM_CONFIGS-1:0]                  out_valid,
    input  logic [NUM_CONFIGS-1:0]                  out_ready,
    input  logic                                    err_clear,
    output logic                                    err_sticky,
    output logic [ERR_CNT_WIDTH-1:0]                err_cnt,
    output logic [ADDR_WIDTH-1:0]                   err_addr
);

    localparam int unsigned IDX_W = (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1;
    localparam int unsigned AXW   = ADDR_WIDTH + 1;

    // Window table must be strictly increasing and fit the address space.
    for (genvar g = 0; g < NUM_CONFIGS; g++) begin : g_bound_chk
        if (ADDR_SPACE_BOUNDS[g] >= ADDR_SPACE_BOUNDS[g+1]) begin : g_err
            $error("config_splitter_reg: bounds not strictly increasing at %0d", g);
        end
    end
    if (ADDR_SPACE_BOUNDS[NUM_CONFIGS] > (64'd1 << ADDR_WIDTH)) begin : g_top_chk
        $error("config_splitter_reg: top bound exceeds address space");
    end

    logic                  stage_valid;
    logic [IDX_W-1:0]      stage_idx;
    logic [ADDR_WIDTH-1:0] stage_addr;
    logic [DATA_WIDTH-1:0] stage_data;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [ADDR_WIDTH-1:0] hit_addr;
    logic [AXW-1:0]        addr_ext;
    logic                  drain;
    logic                  accept;
    logic                  miss;

    // Window decode at ADDR_WIDTH+1 bits so the top bound may equal 2^ADDR_WIDTH.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_addr = '0;
        addr_ext = {1'b0, in_addr};
        for (int i = 0; i < int'(NUM_CONFIGS); i++) begin
            if (addr_ext >= AXW'(ADDR_SPACE_BOUNDS[i]) &&
                addr_ext <  AXW'(ADDR_SPACE_BOUNDS[i+1])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                if (SUBTRACT_BASE != 0) begin
                    hit_addr = ADDR_WIDTH'(addr_ext - AXW'(ADDR_SPACE_BOUNDS[i]));
                end else begin
                    hit_addr = in_addr;
                end
            end
        end
    end

    // Handshake: a stage that drains this cycle can take a new write with no bubble.
    always_comb begin
        drain    = stage_valid && out_ready[stage_idx];
        in_ready = !stage_valid || drain;
        accept   = in_valid && in_ready;
        miss     = accept && !hit;
    end

    // Output stage: load on a hit, empty on drain, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_idx   <= '0;
            stage_addr  <= '0;
            stage_data  <= '0;
        end else if (accept && hit) begin
            stage_valid <= 1'b1;
            stage_idx   <= hit_idx;
            stage_addr  <= hit_addr;
            stage_data  <= in_data;
        end else if (drain) begin
            stage_valid <= 1'b0;
        end
    end

    // Stage fans out to every channel; only the target sees valid.
    always_comb begin
        out_valid = '0;
        out_valid[stage_idx] = stage_valid;
        for (int j = 0; j < int'(NUM_CONFIGS); j++) begin
            out_addr[j] = stage_addr;
            out_data[j] = stage_data;
        end
    end

    // Decode-error bookkeeping; a miss on the clearing edge counts as the first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            err_addr   <= '0;
        end else if (miss) begin
            err_sticky <= 1'b1;
            if (err_clear) begin
                err_cnt <= ERR_CNT_WIDTH'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
            if (err_clear || !err_sticky) begin
                err_addr <= in_addr;
            end
        end else if (err_clear) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            err_addr   <= '0;
        end
    end

endmodule

// File: tb/tb_config_splitter_reg.sv
// Self-checking bench for config_splitter_reg: scoreboard on the default instance,
// plus a second instance with pass-through addresses and a 2-bit error counter.
module tb_config_splitter_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [31:0]      in_addr;
    logic [63:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][31:0] out_addr;
    logic [3:0][63:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             err_clear;
    logic             err_sticky;
    logic [15:0]      err_cnt;
    logic [31:0]      err_addr;

    logic [31:0]      b_in_addr;
    logic [63:0]      b_in_data;
    logic             b_in_valid;
    logic             b_in_ready;
    logic [3:0][31:0] b_out_addr;
    logic [3:0][63:0] b_out_data;
    logic [3:0]       b_out_valid;
    logic [3:0]       b_out_ready;
    logic             b_err_clear;
    logic             b_err_sticky;
    logic [1:0]       b_err_cnt;
    logic [31:0]      b_err_addr;

    config_splitter_reg dut (
        .clk(clk), .rst_n(rst_n),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_clear(err_clear), .err_sticky(err_sticky), .err_cnt(err_cnt), .err_addr(err_addr)
    );

    config_splitter_reg #(.SUBTRACT_BASE(0), .ERR_CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_addr(b_in_addr), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_addr(b_out_addr), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_clear(b_err_clear), .err_sticky(b_err_sticky), .err_cnt(b_err_cnt), .err_addr(b_err_addr)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard: every completed handshake on the default instance pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid != 4'b0) begin
                tests_run++;
                if ($countones(out_valid) != 1) begin
                    tests_failed++;
                    $display("FAIL onehot out_valid=%b required exactly one bit", out_valid);
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (out_valid[j] && out_ready[j]) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_unexpected ch=%0d addr=%h required no transfer", j, out_addr[j]);
                    end else begin
                        e = sb_q.pop_front();
                        if (j != int'(e.ch) || out_addr[j] !== e.addr || out_data[j] !== e.data) begin
                            tests_failed++;
                            $display("FAIL sb_transfer ch=%0d addr=%h data=%h required ch=%0d addr=%h data=%h",
                                     j, out_addr[j], out_data[j], e.ch, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if (out_valid !== 4'b0 || in_ready !== 1'b1 || err_sticky !== 1'b0 ||
            err_cnt !== 16'd0 || err_addr !== 32'd0 || out_addr[0] !== 32'd0 || out_data[3] !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_state valid=%b ready=%b sticky=%b cnt=%0d eaddr=%h addr0=%h data3=%h required 0,1,0,0,0,0,0",
                     out_valid, in_ready, err_sticky, err_cnt, err_addr, out_addr[0], out_data[3]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [4] = '{32'd5, 32'd20, 32'd40, 32'd63};
        logic [31:0] offs  [4] = '{32'd5, 32'd4, 32'd8, 32'd15};
        logic [63:0] d;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k > 0) begin
                tests_run++;
                if (out_valid !== 4'(1 << (k - 1))) begin
                    tests_failed++;
                    $display("FAIL seq_latency k=%0d out_valid=%b required %b", k, out_valid, 4'(1 << (k - 1)));
                end
            end
            d = rnd64();
            in_valid = 1'b1;
            in_addr  = addrs[k];
            in_data  = d;
            sb_q.push_back('{ch: 2'(k), addr: offs[k], data: d});
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq_in_ready k=%0d in_ready=%b required 1", k, in_ready);
            end
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 4'b1000) begin
            tests_failed++;
            $display("FAIL seq_last out_valid=%b required 1000", out_valid);
        end
        tick();
        tests_run++;
        if (out_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL seq_idle out_valid=%b required 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d1 = rnd64();
        logic [63:0] d2 = rnd64();
        out_ready = 4'b1101;
        tick();
        in_valid = 1'b1;
        in_addr  = 32'd17;
        in_data  = d1;
        sb_q.push_back('{ch: 2'd1, addr: 32'd1, data: d1});
        tick();
        in_addr = 32'd2;
        in_data = d2;
        sb_q.push_back('{ch: 2'd0, addr: 32'd2, data: d2});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 4'b0010 || out_addr[1] !== 32'd1 || out_data[1] !== d1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d valid=%b addr=%h data=%h ready=%b required 0010,1,%h,0",
                         i, out_valid, out_addr[1], out_data[1], in_ready, d1);
            end
            tick();
        end
        out_ready = 4'b1111;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drain_ready in_ready=%b valid=%b required 1,0010", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 4'b0001 || out_addr[0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL no_bubble valid=%b addr=%h required 0001,2", out_valid, out_addr[0]);
        end
        tick();
    endtask

    task automatic test_miss();
        tick();
        in_valid = 1'b1;
        in_addr  = 32'd64;
        in_data  = rnd64();
        tick();
        in_addr = 32'd100;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 4'b0) begin
                tests_failed++;
                $display("FAIL miss_no_fwd out_valid=%b required 0000", out_valid);
            end
            tick();
        end
        tests_run++;
        if (err_sticky !== 1'b1 || err_cnt !== 16'd2 || err_addr !== 32'd64) begin
            tests_failed++;
            $display("FAIL miss_err sticky=%b cnt=%0d addr=%0d required 1,2,64", err_sticky, err_cnt, err_addr);
        end
    endtask

    task automatic test_err_clear();
        tick();
        in_valid  = 1'b1;
        in_addr   = 32'd70;
        err_clear = 1'b1;
        tick();
        in_valid  = 1'b0;
        err_clear = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_sticky !== 1'b1 || err_cnt !== 16'd1 || err_addr !== 32'd70) begin
            tests_failed++;
            $display("FAIL clear_with_miss sticky=%b cnt=%0d addr=%0d required 1,1,70", err_sticky, err_cnt, err_addr);
        end
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_sticky !== 1'b0 || err_cnt !== 16'd0 || err_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL clear_alone sticky=%b cnt=%0d addr=%0d required 0,0,0", err_sticky, err_cnt, err_addr);
        end
    endtask

    task automatic test_nosub_saturate();
        logic [63:0] d = rnd64();
        b_out_ready = 4'b1111;
        tick();
        b_in_valid = 1'b1;
        b_in_addr  = 32'd33;
        b_in_data  = d;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b_out_valid !== 4'b0100 || b_out_addr[2] !== 32'd33 || b_out_data[2] !== d) begin
            tests_failed++;
            $display("FAIL nosub_addr valid=%b addr=%0d data=%h required 0100,33,%h", b_out_valid, b_out_addr[2], b_out_data[2], d);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            b_in_valid = 1'b1;
            b_in_addr  = 32'(200 + k);
            tick();
            b_in_valid = 1'b0;
            @(negedge clk);
            tests_run++;
            if (b_err_cnt !== 2'((k > 3) ? 3 : k) || b_err_sticky !== 1'b1 || b_err_addr !== 32'd201) begin
                tests_failed++;
                $display("FAIL sat_cnt k=%0d cnt=%0d sticky=%b addr=%0d required %0d,1,201",
                         k, b_err_cnt, b_err_sticky, b_err_addr, (k > 3) ? 3 : k);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0111;
        tick();
        in_valid = 1'b1;
        in_addr  = 32'd99;
        tick();
        in_addr = 32'd50;
        in_data = rnd64();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 4'b1000 || out_addr[3] !== 32'd2 || err_sticky !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ch3 valid=%b addr=%0d sticky=%b required 1000,2,1", out_valid, out_addr[3], err_sticky);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 4'b0 || err_sticky !== 1'b0 || err_cnt !== 16'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset valid=%b sticky=%b cnt=%0d ready=%b required 0000,0,0,1",
                     out_valid, err_sticky, err_cnt, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 4'b0 || err_cnt !== 16'd0 || err_addr !== 32'd0) begin
                tests_failed++;
                $display("FAIL post_reset cyc=%0d valid=%b cnt=%0d addr=%0d required 0000,0,0", i, out_valid, err_cnt, err_addr);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 4'b1111;
        err_clear   = 1'b0;
        b_in_addr   = '0;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 4'b1111;
        b_err_clear = 1'b0;

        test_reset();
        test_sequential();
        test_back_to_back();
        test_miss();
        test_err_clear();
        test_nosub_saturate();
        test_reset_mid();

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover entries=%0d required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
